montmul_digit: RTL and testbench

- Parametrised Montgomery modular multiplier with a digit-serial (radix 2^DIG) datapath, for the ecc_core arithmetic layer.
- Computes r = a*b*2^(-WID) mod m, fully reduced (0 <= r < m).
- Latches its operands on start and uses a rdy/busy/vld handshake.
- Holds the result stable until the next operation, so the point-arithmetic sequencer can issue back-to-back products.

---
 rtl/ecc_pkg.sv | 24 ++
 rtl/montmul_digit_step.sv | 32 +++
 rtl/montmul_digit.sv | 121 ++++++++++++
 tb/tb_montmul_digit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the ecc_core arithmetic layer: FSM encoding and
// derived sizing helpers for the digit-serial Montgomery multiplier.
package ecc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int calc_iter(input int wid, input int dig);
    return wid / dig;
  endfunction

  // One spare bit so the counter can hold ITER itself without wrapping.
  function automatic int calc_cntwid(input int wid, input int dig);
    return $clog2(wid / dig) + 1;
  endfunction

  function automatic bit dig_legal(input int wid, input int dig);
    return ((dig == 1) || (dig == 2) || (dig == 4) || (dig == 8)) && ((wid % dig) == 0);
  endfunction

endpackage

// File: rtl/montmul_digit_step.sv
// One combinational Montgomery iteration: consumes DIG bits of a and returns
// (acc + ai*b + q*m) / 2^DIG with q chosen to clear the low DIG bits.
module montmul_digit_step #(
  parameter int WID = 256,
  parameter int DIG = 1
) (
  input  logic [WID+DIG+1:0] i_acc,
  input  logic [DIG-1:0]     i_ai,
  input  logic [WID-1:0]     i_b,
  input  logic [WID-1:0]     i_m,
  input  logic [DIG-1:0]     i_mprime,
  output logic [WID+DIG+1:0] o_acc_next
);

  localparam int AW = WID + DIG + 2;

  logic [WID+DIG-1:0] w_ab;
  logic [WID+DIG-1:0] w_qm;
  logic [AW-1:0]      w_t;
  logic [AW-1:0]      w_sum;
  logic [DIG-1:0]     w_q;

  assign w_ab  = {{WID{1'b0}}, i_ai} * {{DIG{1'b0}}, i_b};
  assign w_t   = i_acc + {2'b00, w_ab};
  // Only the low DIG bits of t matter for the quotient digit.
  assign w_q   = w_t[DIG-1:0] * i_mprime;
  assign w_qm  = {{WID{1'b0}}, w_q} * {{DIG{1'b0}}, i_m};
  assign w_sum = w_t + {2'b00, w_qm};

  assign o_acc_next = w_sum >> DIG;

endmodule

// File: rtl/montmul_digit.sv
// Digit-serial Montgomery multiplier: r = a*b*2^(-WID) mod m, fully reduced.
// Handshake: start is taken only while rdy=1; vld pulses once when r updates.
module montmul_digit
  import ecc_pkg::*;
#(
  parameter int WID = 256,
  parameter int DIG = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  input  logic [WID-1:0] m,
  input  logic [DIG-1:0] mprime,
  output logic           rdy,
  output logic           busy,
  output logic           vld,
  output logic [WID-1:0] r
);

  localparam int ITER   = calc_iter(WID, DIG);
  localparam int CNTWID = calc_cntwid(WID, DIG);
  localparam int AW     = WID + DIG + 2;

  if (!dig_legal(WID, DIG)) begin : g_bad_dig
    $error("montmul_digit: DIG must be 1, 2, 4 or 8 and divide WID");
  end

  state_t            r_state;
  logic [CNTWID-1:0] r_cnt;
  logic [AW-1:0]     r_acc;
  logic [WID-1:0]    r_a;
  logic [WID-1:0]    r_b;
  logic [WID-1:0]    r_m;
  logic [DIG-1:0]    r_mprime;
  logic [WID-1:0]    r_res;
  logic              r_rdy;
  logic              r_busy;
  logic              r_vld;

  logic [AW-1:0]     w_acc_next;
  logic [WID-1:0]    w_acc_sub;
  logic [WID-1:0]    w_r_fin;

  montmul_digit_step #(
    .WID(WID),
    .DIG(DIG)
  ) u_step (
    .i_acc      (r_acc),
    .i_ai       (r_a[DIG-1:0]),
    .i_b        (r_b),
    .i_m        (r_m),
    .i_mprime   (r_mprime),
    .o_acc_next (w_acc_next)
  );

  // acc < 2m, so acc - m fits in WID bits whenever the subtraction is taken.
  assign w_acc_sub = r_acc[WID-1:0] - r_m;
  assign w_r_fin   = (r_acc >= {{(DIG+2){1'b0}}, r_m}) ? w_acc_sub : r_acc[WID-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_mprime <= '0;
      r_res    <= '0;
      r_rdy    <= 1'b1;
      r_busy   <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_m      <= m;
            r_mprime <= mprime;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          // a is consumed LSB-first by shifting the latched copy.
          r_acc <= w_acc_next;
          r_a   <= r_a >> DIG;
          r_cnt <= r_cnt + CNTWID'(1);
          if (r_cnt == CNTWID'(ITER - 1)) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_res   <= w_r_fin;
          r_vld   <= 1'b1;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rdy  = r_rdy;
  assign busy = r_busy;
  assign vld  = r_vld;
  assign r    = r_res;

endmodule

// File: tb/tb_montmul_digit.sv
// Bench for montmul_digit: directed 8-bit vectors, back-to-back and reset
// sequences, then random 16-bit operands across all legal digit sizes.
module tb_montmul_digit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // 8-bit instances: index 0 is DIG=1, index 1 is DIG=2.
  logic       start8 [2];
  logic [7:0] a8, b8, m8;
  logic [0:0] mp8d1;
  logic [1:0] mp8d2;
  logic       rdy8   [2];
  logic       busy8  [2];
  logic       vld8   [2];
  logic [7:0] r8     [2];

  // 16-bit instances share operands; index j has DIG = 1 << j.
  logic        start16;
  logic [15:0] a16, b16, m16;
  logic [0:0]  mp16_1;
  logic [1:0]  mp16_2;
  logic [3:0]  mp16_4;
  logic [7:0]  mp16_8;
  logic        rdy16  [4];
  logic        busy16 [4];
  logic        vld16  [4];
  logic [15:0] r16    [4];

  montmul_digit #(.WID(8), .DIG(1)) u8d1 (
    .clk(clk), .rst(rst), .start(start8[0]), .a(a8), .b(b8), .m(m8), .mprime(mp8d1),
    .rdy(rdy8[0]), .busy(busy8[0]), .vld(vld8[0]), .r(r8[0]));
  montmul_digit #(.WID(8), .DIG(2)) u8d2 (
    .clk(clk), .rst(rst), .start(start8[1]), .a(a8), .b(b8), .m(m8), .mprime(mp8d2),
    .rdy(rdy8[1]), .busy(busy8[1]), .vld(vld8[1]), .r(r8[1]));
  montmul_digit #(.WID(16), .DIG(1)) u16d1 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .m(m16), .mprime(mp16_1),
    .rdy(rdy16[0]), .busy(busy16[0]), .vld(vld16[0]), .r(r16[0]));
  montmul_digit #(.WID(16), .DIG(2)) u16d2 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .m(m16), .mprime(mp16_2),
    .rdy(rdy16[1]), .busy(busy16[1]), .vld(vld16[1]), .r(r16[1]));
  montmul_digit #(.WID(16), .DIG(4)) u16d4 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .m(m16), .mprime(mp16_4),
    .rdy(rdy16[2]), .busy(busy16[2]), .vld(vld16[2]), .r(r16[2]));
  montmul_digit #(.WID(16), .DIG(8)) u16d8 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .m(m16), .mprime(mp16_8),
    .rdy(rdy16[3]), .busy(busy16[3]), .vld(vld16[3]), .r(r16[3]));

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int         sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [1:0] mp;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Call at a negedge: the following posedge samples start (cycle 0).
  task automatic drive8(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] m, input logic [1:0] mp);
    a8 = a;
    b8 = b;
    m8 = m;
    if (sel == 0) mp8d1 = mp[0:0];
    else          mp8d2 = mp;
    start8[sel] = 1'b1;
  endtask

  task automatic run8(input vec_t v, input int idx);
    int lat;
    bit rdy_low;
    logic [7:0] e;
    @(negedge clk);
    drive8(v.sel, v.a, v.b, v.m, v.mp);
    exp_q.push_back(v.exp);
    lat = 0;
    rdy_low = 1'b1;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) start8[v.sel] = 1'b0;
      if (vld8[v.sel]) lat = k;
      else if (rdy8[v.sel] || !busy8[v.sel]) rdy_low = 1'b0;
    end
    check($sformatf("vec%0d_latency", idx), lat, v.lat);
    check($sformatf("vec%0d_rdy_low", idx), {31'd0, rdy_low}, 32'd1);
    e = exp_q.pop_front();
    check($sformatf("vec%0d_r", idx), {24'd0, r8[v.sel]}, {24'd0, e});
    @(negedge clk);
    check($sformatf("vec%0d_vld_pulse", idx), {31'd0, vld8[v.sel]}, 32'd0);
  endtask

  function automatic int calc_mp(input int unsigned m, input int dig);
    for (int q = 0; q < (1 << dig); q++) begin
      if (((m * q + 1) & ((1 << dig) - 1)) == 0) return q;
    end
    return 0;
  endfunction

  // Multiply by 2^-1 mod m sixteen times, using the odd-m halving identity.
  function automatic logic [15:0] ref_mont(input int unsigned a, input int unsigned b,
                                           input int unsigned m);
    longint unsigned x;
    x = (longint'(a) * longint'(b)) % longint'(m);
    repeat (16) begin
      if (x[0]) x = x + longint'(m);
      x = x >> 1;
    end
    return x[15:0];
  endfunction

  task automatic run16(input int unsigned a, input int unsigned b, input int unsigned m, input int n);
    int cnt [4];
    int lat [4];
    logic [15:0] rr [4];
    logic [15:0] e;
    int exp_lat [4];
    exp_lat = '{18, 10, 6, 4};
    for (int j = 0; j < 4; j++) begin
      cnt[j] = 0;
      lat[j] = -1;
      rr[j]  = '0;
    end
    e = ref_mont(a, b, m);
    @(negedge clk);
    a16 = a[15:0];
    b16 = b[15:0];
    m16 = m[15:0];
    mp16_1 = 1'(calc_mp(m, 1));
    mp16_2 = 2'(calc_mp(m, 2));
    mp16_4 = 4'(calc_mp(m, 4));
    mp16_8 = 8'(calc_mp(m, 8));
    start16 = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) start16 = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (vld16[j]) begin
          cnt[j]++;
          if (cnt[j] == 1) begin
            lat[j] = k;
            rr[j]  = r16[j];
          end
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rand%0d_dig%0d_latency", n, 1 << j), (cnt[j] == 1) ? lat[j] : -1, exp_lat[j]);
      check($sformatf("rand%0d_dig%0d_r", n, 1 << j), {16'd0, rr[j]}, {16'd0, e});
    end
  endtask

  initial begin
    int k;
    bit hold_ok;
    int vld_seen;
    int unsigned ra, rb, rm;

    start8[0] = 1'b0;
    start8[1] = 1'b0;
    start16   = 1'b0;
    a8 = '0; b8 = '0; m8 = '0; mp8d1 = '0; mp8d2 = '0;
    a16 = '0; b16 = '0; m16 = '0; mp16_1 = '0; mp16_2 = '0; mp16_4 = '0; mp16_8 = '0;

    vecs[0] = '{0, 8'd5,   8'd7,   8'd13,  2'd1, 8'd1, 10};
    vecs[1] = '{1, 8'd12,  8'd12,  8'd13,  2'd3, 8'd3, 6};
    vecs[2] = '{1, 8'd1,   8'd1,   8'd13,  2'd3, 8'd3, 6};
    vecs[3] = '{1, 8'd0,   8'd9,   8'd13,  2'd3, 8'd0, 6};
    vecs[4] = '{0, 8'd254, 8'd254, 8'd255, 2'd1, 8'd1, 10};
    vecs[5] = '{0, 8'd12,  8'd12,  8'd13,  2'd1, 8'd3, 10};
    vecs[6] = '{1, 8'd5,   8'd7,   8'd13,  2'd3, 8'd1, 6};

    // Clock/reset
    repeat (3) @(negedge clk);
    check("reset_rdy",  {31'd0, rdy8[0]},  32'd1);
    check("reset_busy", {31'd0, busy8[0]}, 32'd0);
    check("reset_vld",  {31'd0, vld8[0]},  32'd0);
    check("reset_r",    {24'd0, r8[0]},    32'd0);
    check("reset_r16",  {16'd0, r16[3]},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run8(vecs[i], i);

    // Back-to-back: second start in the vld cycle; a stray start and operand
    // toggles while busy must not disturb the second product.
    @(negedge clk);
    drive8(0, 8'd12, 8'd12, 8'd13, 2'd1);
    k = 0;
    for (int c = 1; c <= 30 && k == 0; c++) begin
      @(negedge clk);
      if (c == 1) start8[0] = 1'b0;
      if (vld8[0]) k = c;
    end
    check("b2b_first_latency", k, 10);
    check("b2b_first_r", {24'd0, r8[0]}, 32'd3);
    drive8(0, 8'd5, 8'd7, 8'd13, 2'd1);
    hold_ok = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start8[0] = 1'b0;
      if (c == 3) begin
        a8 = 8'd1; b8 = 8'd1; start8[0] = 1'b1;
      end
      if (c == 4) begin
        a8 = 8'd12; b8 = 8'd3; start8[0] = 1'b0;
      end
      if (c < 10 && (vld8[0] || r8[0] !== 8'd3)) hold_ok = 1'b0;
      if (c == 10) begin
        check("b2b_second_vld", {31'd0, vld8[0]}, 32'd1);
        check("b2b_second_r", {24'd0, r8[0]}, 32'd1);
      end
    end
    check("b2b_r_held", {31'd0, hold_ok}, 32'd1);
    @(negedge clk);
    check("b2b_vld_pulse", {31'd0, vld8[0]}, 32'd0);

    // Reset mid-operation aborts without a vld.
    @(negedge clk);
    drive8(0, 8'd12, 8'd12, 8'd13, 2'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start8[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rdy",  {31'd0, rdy8[0]},  32'd1);
    check("abort_busy", {31'd0, busy8[0]}, 32'd0);
    check("abort_vld",  {31'd0, vld8[0]},  32'd0);
    check("abort_r",    {24'd0, r8[0]},    32'd0);
    vld_seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (vld8[0]) vld_seen++;
    end
    check("abort_no_vld", vld_seen, 0);
    run8(vecs[0], 100);

    // Random 16-bit operands across all digit sizes.
    for (int n = 0; n < 1000; n++) begin
      if (n == 0) begin
        rm = 65535; ra = 65534; rb = 65534;
      end else begin
        rm = $urandom_range(65535, 3) | 32'd1;
        ra = $urandom_range(rm - 1, 0);
        rb = $urandom_range(rm - 1, 0);
      end
      run16(ra, rb, rm, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
